// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and round-transform functions
// Purpose: FSM state encoding, round count and pure byte/state transforms used by
//          the round controller and the byte-substitution stage.
// Ports:   none (package). State layout: byte 0 in [127:120], bytes column-major.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } fsm_state_e;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Row r of the output column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gf_mul(8'h0e, a[r]) ^ gf_mul(8'h0b, a[(r+1)%4])
                                ^ gf_mul(8'h0d, a[(r+2)%4]) ^ gf_mul(8'h09, a[(r+3)%4]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block request/result bundle of the AES round controller
// Purpose: groups the start/data/key/result signals of aes_round_ctrl.
// Ports:   master = requester (drives start, inverse, dataIn, roundKey);
//          slave  = controller (drives keyIdx, dataOut, busy, done).
interface aes_round_ctrl_if;
  logic         start;
  logic         inverse;
  logic [127:0] dataIn;
  logic [127:0] roundKey;
  logic [3:0]   keyIdx;
  logic [127:0] dataOut;
  logic         busy;
  logic         done;

  modport master (
    output start, inverse, dataIn, roundKey,
    input  keyIdx, dataOut, busy, done
  );

  modport slave (
    input  start, inverse, dataIn, roundKey,
    output keyIdx, dataOut, busy, done
  );
endinterface

// File: rtl/subBytesAll.sv
// rtl/subBytesAll.sv - 16-byte SubBytes/InvSubBytes with one register stage
// Purpose: substitutes all state bytes; subOut is valid the cycle after subIn.
// Ports:   clk; inverse (1 = inverse S-box); subIn[127:0]; subOut[127:0] (registered).
module subBytesAll
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         inverse,
  input  logic [127:0] subIn,
  output logic [127:0] subOut
);

  logic [127:0] sub_d;

  always_comb begin
    sub_d = '0;
    for (int i = 0; i < 16; i++)
      sub_d[127-8*i -: 8] = inverse ? inv_sbox(subIn[127-8*i -: 8])
                                    : sbox(subIn[127-8*i -: 8]);
  end

  // Pure datapath register: its content is only consumed in MIX, after a SUB
  // cycle has refreshed it, so it needs no reset.
  always_ff @(posedge clk) begin
    subOut <= sub_d;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encrypt/decrypt round controller
// Purpose: runs 10 rounds over one shared registered SubBytes stage, two cycles
//          per round; done pulses 21 cycles after a start is accepted.
// Ports:   clk; rst (sync, active-high); bus (slave): start, inverse, dataIn,
//          roundKey in; keyIdx, dataOut, busy, done out.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  aes_round_ctrl_if.slave bus
);

  fsm_state_e   fsm_q, fsm_d;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic         inv_q;
  logic [127:0] data_out_q;
  logic         done_q;
  logic [127:0] sub_in, sub_out, round_res;
  logic [3:0]   key_idx;
  logic         last_round;

  subBytesAll u_sub (
    .clk     (clk),
    .inverse (inv_q),
    .subIn   (sub_in),
    .subOut  (sub_out)
  );

  assign last_round = (round_q == NUM_ROUNDS);

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (bus.start) fsm_d = SUB;
      SUB:     fsm_d = MIX;
      MIX:     fsm_d = last_round ? IDLE : SUB;
      default: fsm_d = IDLE;
    endcase
  end

  // In IDLE the first key must already match the request being offered, so it
  // follows the live inverse input rather than the latched one.
  always_comb begin
    key_idx = 4'd0;
    if (fsm_q == IDLE) key_idx = bus.inverse ? NUM_ROUNDS : 4'd0;
    else               key_idx = inv_q ? (NUM_ROUNDS - round_q) : round_q;
  end

  // Decrypt applies InvShiftRows before substitution; the two commute, which
  // lets both directions share the SUB->MIX timing.
  assign sub_in = inv_q ? invShiftRows(state_q) : state_q;

  always_comb begin
    round_res = '0;
    if (!inv_q) begin
      round_res = shiftRows(sub_out);
      if (!last_round) round_res = mixColumns(round_res);
      round_res = round_res ^ bus.roundKey;
    end else begin
      round_res = sub_out ^ bus.roundKey;
      if (!last_round) round_res = invMixColumns(round_res);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q    <= 4'd0;
      state_q    <= '0;
      inv_q      <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= bus.dataIn ^ bus.roundKey;
            round_q <= 4'd1;
            inv_q   <= bus.inverse;
          end
        end
        MIX: begin
          state_q <= round_res;
          if (last_round) begin
            data_out_q <= round_res;
            done_q     <= 1'b1;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.keyIdx  = key_idx;
  assign bus.dataOut = data_out_q;
  assign bus.busy    = (fsm_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit; request to process one block, sampled only when idle.
REQ-004 SHALL have port inverse, input, 1 bit; 0 = encrypt, 1 = decrypt; sampled with start and held internally for the whole block.
REQ-005 SHALL have port dataIn, input, 128 bits; plaintext or ciphertext block, sampled with start; byte 0 is in [127:120].
REQ-006 SHALL have port roundKey, input, 128 bits; expanded round key selected by keyIdx, valid combinationally in the same cycle.
REQ-007 SHALL have port keyIdx, output, 4 bits; combinational round-key index, 0..10.
REQ-008 SHALL have port dataOut, output, 128 bits; result block, valid while done=1 and held until the next accepted start.
REQ-009 SHALL have port busy, output, 1 bit; high from the cycle after start is accepted until the cycle done is raised.
REQ-010 SHALL have port done, output, 1 bit; one-cycle completion pulse.

Function
REQ-011 SHALL use one shared subBytesAll instance with 1-cycle registered latency (subOut valid the cycle after subIn) for all 10 rounds.
REQ-012 SHALL implement FSM states IDLE, SUB, MIX; transitions: IDLE->SUB on accepted start, SUB->MIX always, MIX->SUB if round<10, MIX->IDLE if round=10.
REQ-013 SHALL keep a 4-bit round counter: set to 1 on accept, incremented in each MIX when round<10.
REQ-014 SHALL drive keyIdx in IDLE: inverse input ? 10 : 0; in SUB and MIX: encrypt = round, decrypt = 10-round.
REQ-015 SHALL, on accept in IDLE, load state <= dataIn XOR roundKey.
REQ-016 SHALL, in SUB, drive subIn = state (encrypt) or InvShiftRows(state) (decrypt), with the subBytesAll inverse input = latched inverse.
REQ-017 SHALL, in MIX when encrypting, load state <= MixColumns(ShiftRows(subOut)) XOR roundKey; MixColumns is omitted when round=10.
REQ-018 SHALL, in MIX when decrypting, load state <= InvMixColumns(subOut XOR roundKey); InvMixColumns is omitted when round=10.
REQ-019 SHALL, on MIX with round=10, copy the new state into dataOut and pulse done for exactly one cycle while the FSM returns to IDLE.
REQ-020 SHALL have fixed latency: done high exactly 21 cycles after the cycle start was accepted; throughput is one block per 21 cycles.
REQ-021 SHALL accept start in the same cycle done is high (back-to-back), because the FSM is then in IDLE.
REQ-022 SHALL ignore start while busy, with no effect on the state, round counter or outputs.
REQ-023 SHALL make the subIn value in IDLE don't-care; subOut is used only in MIX.

Reset
REQ-024 SHALL, with rst high at a clock edge, force FSM=IDLE, round=0, busy=0, done=0, dataOut=0, state=0 and latched inverse=0.
REQ-025 SHALL let rst abort any block in progress with no done pulse; start is accepted again in the first cycle after rst deasserts.
REQ-026 SHALL give rst priority over start in the same cycle.

Structure
REQ-027 SHALL place the following in shared package aes_pkg: FSM state encoding, NUM_ROUNDS=10, and pure functions xtime, shiftRows, invShiftRows, mixColumns, invMixColumns.
REQ-028 SHALL instantiate subBytesAll as its single sub-module; all other logic is local registers plus aes_pkg functions.

Verification (bench models the key schedule and answers keyIdx combinationally)
REQ-029 SHALL cover encrypt: key 000102030405060708090a0b0c0d0e0f, dataIn 00112233445566778899aabbccddeeff -> dataOut 69c4e0d86a7b0430d8cdb78070b4c55a, done 21 cycles after start.
REQ-030 SHALL cover decrypt: same key, dataIn 69c4e0d86a7b0430d8cdb78070b4c55a, inverse=1 -> dataOut 00112233445566778899aabbccddeeff; keyIdx sequence 10,9,...,0 observed.
REQ-031 SHALL cover back-to-back: start held high across done, blocks encrypt then decrypt -> two correct results exactly 21 cycles apart, with no lost block.
REQ-032 SHALL cover start while busy: pulse start with a different dataIn at cycle 5 of a block -> first result unchanged and no second done.
REQ-033 SHALL cover reset mid-block: assert rst at cycle 10 -> busy=0, done=0, dataOut=0 the next cycle; a new encrypt afterwards gives the REQ-029 result.
REQ-034 SHALL cover a randomized set of 200 encrypt/decrypt pairs against a reference model -> decrypt(encrypt(x)) = x, with done always one cycle wide.
